// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers, with bursts of up to BURST_LEN.
// Optional FIFO_ARB_STATS_EN adds saturating per-requester stall counters (stall0/stall1).
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic                  full,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] w_data
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall0,
    output logic [CNT_WIDTH-1:0]  stall1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_L = 8'(BURST_LEN);

    state_t     st_q, st_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       g0, g1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= IDLE;
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        g0      = 1'b0;
        g1      = 1'b0;
        cnt_inc = cnt_q + 8'd1;
        if (!full) begin
            if (st_q == OWN0 && req0) begin
                g0    = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc == BURST_L) st_d = IDLE;
            end else if (st_q == OWN1 && req1) begin
                g1    = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc == BURST_L) st_d = IDLE;
            end else begin
                // Owner dropped (or idle): re-arbitrate in the same cycle so there is no bubble.
                st_d = IDLE;
                if (req0 && (last_q || !req1)) begin
                    g0     = 1'b1;
                    last_d = 1'b0;
                    cnt_d  = 8'd1;
                    if (BURST_L != 8'd1) st_d = OWN0;
                end else if (req1) begin
                    g1     = 1'b1;
                    last_d = 1'b1;
                    cnt_d  = 8'd1;
                    if (BURST_L != 8'd1) st_d = OWN1;
                end
            end
        end
    end

    // Reset gates the combinational grant path so nothing is written while it is asserted.
    assign gnt0   = g0 & ~reset;
    assign gnt1   = g1 & ~reset;
    assign wr     = gnt0 | gnt1;
    assign w_data = gnt0 ? data0 : (gnt1 ? data1 : '0);

`ifdef FIFO_ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] stall0_q, stall0_d;
    logic [CNT_WIDTH-1:0] stall1_q, stall1_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else begin
            stall0_q <= stall0_d;
            stall1_q <= stall1_d;
        end
    end

    always_comb begin
        stall0_d = stall0_q;
        stall1_d = stall1_q;
        if (req0 && !gnt0 && stall0_q != '1) stall0_d = stall0_q + ONE;
        if (req1 && !gnt1 && stall1_q != '1) stall1_d = stall1_q + ONE;
    end

    assign stall0 = stall0_q;
    assign stall1 = stall1_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (BURST_LEN = 4); stall checks only when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, full = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, wr;
    logic [DW-1:0] w_data;
`ifdef FIFO_ARB_STATS_EN
    logic [7:0]    stall0, stall1;
`endif

    int            n_cmp = 0;
    int            n_err = 0;
    logic [15:0]   cyc = '0;
    logic [DW+2:0] act, exp_v;

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .BURST_LEN (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .data0 (data0),
        .data1 (data1),
        .full  (full),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .wr    (wr),
        .w_data(w_data)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall0(stall0),
        .stall1(stall1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW+2:0] expect_vec(input logic e0, input logic e1);
        logic [DW-1:0] d;
        d = e0 ? data0 : (e1 ? data1 : '0);
        return {e0, e1, e0 | e1, d};
    endfunction

    // Drive one cycle of inputs at the falling edge; outputs are then sampled 1 time unit later.
    task automatic drive(input logic r0, input logic r1, input logic f);
        @(negedge clk);
        req0  = r0;
        req1  = r1;
        full  = f;
        data0 = {8'hA0, cyc};
        data1 = {8'hB0, cyc};
        cyc   = cyc + 16'd1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 24'h123456;
        data1 = 24'h654321;
        #1;
        for (int i = 0; i < 2; i++) begin
            act = {gnt0, gnt1, wr, w_data};
            n_cmp++;
            if (act !== '0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", i, act);
            end
            @(negedge clk);
            #1;
        end
`ifdef FIFO_ARB_STATS_EN
        n_cmp++;
        if (stall0 !== 8'd0 || stall1 !== 8'd0) begin
            n_err++;
            $display("FAIL reset_stall: got %0d/%0d expected 0/0", stall0, stall1);
        end
`endif
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
    endtask

    task automatic test_round_robin();
        logic e0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            e0    = ((i / 4) % 2) == 0;
            exp_v = expect_vec(e0, !e0);
            act   = {gnt0, gnt1, wr, w_data};
            n_cmp++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL round_robin[%0d]: got %h expected %h", i, act, exp_v);
            end
        end
    endtask

    task automatic test_single_req();
        logic e0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_v = expect_vec(1'b1, 1'b0);
            act   = {gnt0, gnt1, wr, w_data};
            n_cmp++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL single_req[%0d]: got %h expected %h", i, act, exp_v);
            end
        end
        // Third burst holds 2 grants; it finishes before requester 1 gets a turn.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            e0    = (i < 2);
            exp_v = expect_vec(e0, !e0);
            act   = {gnt0, gnt1, wr, w_data};
            n_cmp++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL single_then_both[%0d]: got %h expected %h", i, act, exp_v);
            end
        end
    endtask

    task automatic test_full_pause();
        logic e0, e1, f;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            f = (i >= 2 && i <= 4);
            drive(1'b1, 1'b1, f);
`ifdef FIFO_ARB_STATS_EN
            if (i == 5) begin
                n_cmp++;
                if (stall0 !== 8'd3 || stall1 !== 8'd5) begin
                    n_err++;
                    $display("FAIL full_stall: got %0d/%0d expected 3/5", stall0, stall1);
                end
            end
`endif
            e0    = (i <= 1) || (i == 5) || (i == 6) || (i == 11);
            e1    = (i >= 7 && i <= 10);
            exp_v = expect_vec(e0, e1);
            act   = {gnt0, gnt1, wr, w_data};
            n_cmp++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL full_pause[%0d]: got %h expected %h", i, act, exp_v);
            end
        end
    endtask

    task automatic test_owner_drop();
        logic e0, r0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            r0 = (i != 2);
            drive(r0, 1'b1, 1'b0);
            e0    = (i <= 1) || (i == 6);
            exp_v = expect_vec(e0, !e0);
            act   = {gnt0, gnt1, wr, w_data};
            n_cmp++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL owner_drop[%0d]: got %h expected %h", i, act, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        logic e0;
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        exp_v = expect_vec(1'b1, 1'b0);
        act   = {gnt0, gnt1, wr, w_data};
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL pre_async_reset: got %h expected %h", act, exp_v);
        end
        reset = 1'b1;
        #1;
        act = {gnt0, gnt1, wr, w_data};
        n_cmp++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %h expected 0", act);
        end
        @(negedge clk);
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            e0    = (i < 4);
            exp_v = expect_vec(e0, !e0);
            act   = {gnt0, gnt1, wr, w_data};
            n_cmp++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL post_async_reset[%0d]: got %h expected %h", i, act, exp_v);
            end
        end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        n_cmp++;
        if (stall1 !== 8'd255 || stall0 !== 8'd0) begin
            n_err++;
            $display("FAIL stats_saturate: got %0d/%0d expected 0/255", stall0, stall1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_req();
        test_full_pause();
        test_owner_drop();
        test_async_reset();
`ifdef FIFO_ARB_STATS_EN
        test_stats_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
